// File: rtl/ps2_frame_gen.sv
// PS/2 device-side frame generator: queued bytes are sent as 11-bit frames on open-drain clk/data.
// Optional macro PS2_FRAME_GEN_ERR_EN adds per-byte parity/stop error injection (wr_perr, wr_serr).
module ps2_frame_gen #(
  parameter int HALF_CYC   = 1925,
  parameter int GAP_CYC    = 3850,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
`ifdef PS2_FRAME_GEN_ERR_EN
  input  logic                          wr_perr,
  input  logic                          wr_serr,
`endif
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf,
  output logic                          busy,
  output logic                          frame_done,
  input  logic                          ps2_clk_in,
  output logic                          ps2_clk_low,
  output logic                          ps2_data_low
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int CMAX = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
  localparam int CW   = $clog2(CMAX) + 1;
`ifdef PS2_FRAME_GEN_ERR_EN
  localparam int EW   = 10;
`else
  localparam int EW   = 8;
`endif
  localparam logic [CW-1:0] H_LAST  = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0] H_MID   = CW'(HALF_CYC / 2);
  localparam logic [CW-1:0] G_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] INH_MIN = CW'(3);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_HIGH, S_LOW, S_GAP, S_INHIB} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic            clk_low_q, clk_low_d;
  logic            data_low_q, data_low_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic [1:0]      sync_q;
  logic            clk_s;

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wp_q, rp_q;
  logic [LW-1:0]   level_q, level_d;
  logic [EW-1:0]   entry_in;
  logic [EW-1:0]   head;
  logic            push, pop;

  // Line level for frame bit idx of entry e: start, d0..d7, odd parity, stop.
  function automatic logic bit_val(input logic [EW-1:0] e, input logic [3:0] idx);
    logic [3:0] k;
    logic       v;
    k = idx - 4'd1;
    case (idx)
      4'd0:    v = 1'b0;
      4'd9:    v = ~^e[7:0];
      4'd10:   v = 1'b1;
      default: v = e[k[2:0]];
    endcase
`ifdef PS2_FRAME_GEN_ERR_EN
    if (idx == 4'd9)  v = v ^ e[8];
    if (idx == 4'd10) v = v & ~e[9];
`endif
    return v;
  endfunction

`ifdef PS2_FRAME_GEN_ERR_EN
  assign entry_in = {wr_serr, wr_perr, wr_data};
`else
  assign entry_in = wr_data;
`endif

  assign clk_s = sync_q[1];
  assign head  = mem[rp_q];
  assign full  = (level_q == DEPTH_L);
  // A push while full is still accepted when the same cycle pops the head.
  assign push  = wr_en & (~full | pop);
  assign ovf_d = wr_en & full & ~pop;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    bit_d      = bit_q;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        cnt_d      = '0;
        if (level_q != '0) begin
          if (clk_s) begin
            state_d = S_HIGH;
            bit_d   = 4'd0;
          end else begin
            state_d = S_INHIB;
          end
        end
      end
      S_HIGH: begin
        clk_low_d = 1'b0;
        if (cnt_q == H_MID) data_low_d = ~bit_val(head, bit_q);
        // Early HIGH counts still see our own released clock through the synchroniser.
        if (cnt_q >= INH_MIN && !clk_s) begin
          state_d    = S_INHIB;
          data_low_d = 1'b0;
          cnt_d      = '0;
        end else if (cnt_q == H_LAST) begin
          state_d   = S_LOW;
          clk_low_d = 1'b1;
          cnt_d     = '0;
        end
      end
      S_LOW: begin
        if (cnt_q == H_LAST) begin
          cnt_d     = '0;
          clk_low_d = 1'b0;
          if (bit_q < 4'd10) begin
            bit_d   = bit_q + 4'd1;
            state_d = S_HIGH;
          end else begin
            state_d    = S_GAP;
            data_low_d = 1'b0;
            pop        = 1'b1;
            done_d     = 1'b1;
          end
        end
      end
      S_GAP: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        if (cnt_q == G_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_INHIB: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        cnt_d      = '0;
        if (clk_s) state_d = S_GAP;
      end
      default: begin
        state_d    = S_IDLE;
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        cnt_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= 4'd0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      sync_q     <= 2'b11;
      wp_q       <= '0;
      rp_q       <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      sync_q     <= {sync_q[0], ps2_clk_in};
      level_q    <= level_d;
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
    end
  end

  // Queue storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= entry_in;
  end

  assign level        = level_q;
  assign ovf          = ovf_q;
  assign busy         = (state_q != S_IDLE) | (level_q != '0);
  assign frame_done   = done_q;
  assign ps2_clk_low  = clk_low_q;
  assign ps2_data_low = data_low_q;

endmodule

// File: tb/tb_ps2_frame_gen.sv
// Self-checking bench for ps2_frame_gen: vector table, hand-written corner sequences, random bursts.
module tb_ps2_frame_gen;
  localparam int H  = 8;
  localparam int G  = 16;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
`ifdef PS2_FRAME_GEN_ERR_EN
  logic          wr_perr = 1'b0;
  logic          wr_serr = 1'b0;
`endif
  logic          full, ovf, busy, frame_done;
  logic [LW-1:0] level;
  logic          ps2_clk_in, ps2_clk_low, ps2_data_low;
  logic          host_inh = 1'b0;

  always #5 clk = ~clk;

  // Open-drain bus: released clock reads high unless someone pulls it down.
  assign ps2_clk_in = ~(ps2_clk_low | host_inh);

  ps2_frame_gen #(.HALF_CYC(H), .GAP_CYC(G), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
`ifdef PS2_FRAME_GEN_ERR_EN
    .wr_perr(wr_perr), .wr_serr(wr_serr),
`endif
    .full(full), .level(level), .ovf(ovf), .busy(busy), .frame_done(frame_done),
    .ps2_clk_in(ps2_clk_in), .ps2_clk_low(ps2_clk_low), .ps2_data_low(ps2_data_low)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Receiver-side monitor: samples bus data at each falling bus clock.
  logic [10:0] sh = '0;
  int          nb = 0, idle = 0, fd_cnt = 0, ovf_cnt = 0, fall_cnt = 0;
  logic        prev_cl = 1'b0;
  logic [10:0] rx_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      nb      <= 0;
      idle    <= 0;
      prev_cl <= 1'b0;
    end else begin
      if (ps2_clk_low && !prev_cl) begin
        if (nb == 10) begin
          rx_q.push_back({~ps2_data_low, sh[9:0]});
          nb <= 0;
        end else begin
          sh[nb] <= ~ps2_data_low;
          nb     <= nb + 1;
        end
        idle     <= 0;
        fall_cnt <= fall_cnt + 1;
      end else begin
        idle <= idle + 1;
        if (idle > 3 * H) nb <= 0;
      end
      if (frame_done) fd_cnt  <= fd_cnt + 1;
      if (ovf)        ovf_cnt <= ovf_cnt + 1;
      prev_cl <= ps2_clk_low;
    end
  end

  // Reference frame built from the protocol rules: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_model(input logic [7:0] d, input logic pe, input logic se);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    if (pe) f[9] = ~f[9];
    f[10] = ~se;
    return f;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic pe, input logic se);
    wr_data = d;
    wr_en   = 1'b1;
`ifdef PS2_FRAME_GEN_ERR_EN
    wr_perr = pe;
    wr_serr = se;
`else
    if (pe || se) $display("note: error injection requested without PS2_FRAME_GEN_ERR_EN");
`endif
  endtask

  task automatic push1(input logic [7:0] d, input logic pe, input logic se);
    drive_byte(d, pe, se);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_fd(output int cyc);
    cyc = 0;
    do begin step(); cyc++; end while (frame_done !== 1'b1 && cyc < 4000);
    check("frame_done_seen", frame_done, 1);
  endtask

  task automatic wait_clk_low(output int cyc);
    cyc = 0;
    do begin step(); cyc++; end while (ps2_clk_low !== 1'b1 && cyc < 2000);
    check("clk_low_seen", ps2_clk_low, 1);
  endtask

  task automatic wait_nb(input int n);
    int c;
    c = 0;
    while (nb != n && c < 2000) begin step(); c++; end
    check("bit_count_reached", nb, n);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 5000) begin step(); c++; end
    repeat (G + 4) step();
    check("idle_busy", busy, 0);
    check("idle_clk_released", ps2_clk_low, 0);
    check("idle_data_released", ps2_data_low, 0);
  endtask

  task automatic expect_frame(input logic [10:0] exp);
    check("rx_frame_avail", (rx_q.size() != 0), 1);
    if (rx_q.size() != 0) check("rx_frame", rx_q.pop_front(), exp);
  endtask

  typedef struct {
    logic [7:0]  d;
    logic        pe;
    logic        se;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, f0, fl0, o0, len, acc;
    logic [7:0] b;
    logic pe, se;
    logic [10:0] mq[$];

    tbl.push_back('{8'h1C, 1'b0, 1'b0, 11'h438});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 11'h600});
    tbl.push_back('{8'hFF, 1'b0, 1'b0, 11'h7FE});
    tbl.push_back('{8'hA5, 1'b0, 1'b0, 11'h74A});
    tbl.push_back('{8'h01, 1'b0, 1'b0, 11'h402});
    tbl.push_back('{8'h80, 1'b0, 1'b0, 11'h500});
`ifdef PS2_FRAME_GEN_ERR_EN
    tbl.push_back('{8'h1C, 1'b1, 1'b0, 11'h638});
    tbl.push_back('{8'h1C, 1'b0, 1'b1, 11'h038});
`endif

    // Reset state
    repeat (3) step();
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_clk_low", ps2_clk_low, 0);
    check("rst_data_low", ps2_data_low, 0);
    rst = 1'b1;
    repeat (4) step();

    // Table-driven single frames: bits, latency, pulse width, occupancy
    foreach (tbl[i]) begin
      push1(tbl[i].d, tbl[i].pe, tbl[i].se);
      check("busy_after_push", busy, 1);
      wait_fd(cyc);
      check("frame_latency", cyc, 22 * H + 1);
      check("level_after_frame", level, 0);
      expect_frame(tbl[i].exp);
      step();
      check("frame_done_one_cycle", frame_done, 0);
      wait_idle();
    end

    // Back-to-back bytes: level 2->1->0 and inter-frame spacing
    drive_byte(8'h00, 1'b0, 1'b0);
    step();
    drive_byte(8'hFF, 1'b0, 1'b0);
    step();
    wr_en = 1'b0;
    check("b2b_level2", level, 2);
    wait_fd(cyc);
    check("b2b_level1", level, 1);
    wait_clk_low(cyc);
    check("b2b_gap_to_first_fall", cyc, G + 1 + H);
    wait_fd(cyc);
    check("b2b_level0", level, 0);
    expect_frame(frame_model(8'h00, 1'b0, 1'b0));
    expect_frame(frame_model(8'hFF, 1'b0, 1'b0));
    wait_idle();

    // Overflow: five consecutive pushes into a depth-4 queue
    o0 = ovf_cnt;
    f0 = fd_cnt;
    for (int k = 1; k <= 5; k++) begin
      drive_byte(8'(k * 16 + 3), 1'b0, 1'b0);
      step();
      check("ovf_level", level, (k >= D) ? D : k);
      check("ovf_full", full, (k >= D) ? 1 : 0);
      check("ovf_pulse", ovf, (k == 5) ? 1 : 0);
    end
    wr_en = 1'b0;
    step();
    check("ovf_pulse_end", ovf, 0);
    for (int k = 1; k <= D; k++) begin
      wait_fd(cyc);
      expect_frame(frame_model(8'(k * 16 + 3), 1'b0, 1'b0));
    end
    repeat (2 * (22 * H + G + H)) step();
    check("ovf_frames_emitted", fd_cnt - f0, D);
    check("ovf_pulse_count", ovf_cnt - o0, 1);
    check("ovf_no_extra_rx", rx_q.size(), 0);
    wait_idle();

    // Host inhibit during the HIGH phase of bit 5, then whole-frame resend
    f0 = fd_cnt;
    push1(8'hA5, 1'b0, 1'b0);
    wait_nb(5);
    cyc = 0;
    while (ps2_clk_low !== 1'b0 && cyc < 100) begin step(); cyc++; end
    repeat (3) step();
    host_inh = 1'b1;
    repeat (2) step();
    check("inh_data_driven_before", ps2_data_low, 1);
    step();
    check("inh_clk_released", ps2_clk_low, 0);
    check("inh_data_released", ps2_data_low, 0);
    repeat (40) step();
    check("inh_no_frame_done", fd_cnt - f0, 0);
    check("inh_still_released", ps2_clk_low, 0);
    check("inh_no_partial_rx", rx_q.size(), 0);
    check("inh_level_kept", level, 1);
    host_inh = 1'b0;
    wait_clk_low(cyc);
    check("inh_release_to_first_fall", cyc, 4 + G + H);
    wait_fd(cyc);
    expect_frame(frame_model(8'hA5, 1'b0, 1'b0));
    check("inh_single_frame_done", fd_cnt - f0, 1);
    wait_idle();

    // Asynchronous reset during bit 7 LOW
    push1(8'h1C, 1'b0, 1'b0);
    push1(8'h01, 1'b0, 1'b0);
    wait_nb(8);
    check("rstmid_clk_low_before", ps2_clk_low, 1);
    check("rstmid_data_low_before", ps2_data_low, 1);
    check("rstmid_level_before", level, 2);
    #2 rst = 1'b0;
    #1;
    check("rstmid_clk_released", ps2_clk_low, 0);
    check("rstmid_data_released", ps2_data_low, 0);
    check("rstmid_level", level, 0);
    check("rstmid_busy", busy, 0);
    repeat (2) step();
    rst = 1'b1;
    f0  = fd_cnt;
    fl0 = fall_cnt;
    repeat (300) step();
    check("rstmid_no_frame", fd_cnt - f0, 0);
    check("rstmid_no_clock", fall_cnt - fl0, 0);
    check("rstmid_idle", busy, 0);
    rx_q.delete();

    // Random bursts against the queue model
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 6);
      acc = (len > D) ? D : len;
      o0  = ovf_cnt;
      mq.delete();
      for (int i = 0; i < len; i++) begin
        b  = 8'($urandom);
        pe = 1'b0;
        se = 1'b0;
`ifdef PS2_FRAME_GEN_ERR_EN
        pe = 1'($urandom_range(0, 1));
        se = 1'($urandom_range(0, 1));
`endif
        drive_byte(b, pe, se);
        if (i < D) mq.push_back(frame_model(b, pe, se));
        step();
      end
      wr_en = 1'b0;
      step();
      check("rand_ovf_count", ovf_cnt - o0, len - acc);
      for (int i = 0; i < acc; i++) begin
        wait_fd(cyc);
        expect_frame(mq[i]);
      end
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
